// File: rtl/lcd_ctrl.sv
// HD44780-style character-LCD write sequencer: runs the panel power-up/init
// sequence after reset, then writes one command or data byte per accepted request.
module lcd_ctrl #(
  parameter int unsigned T_PWR   = 2000000,
  parameter int unsigned T_SETUP = 4,
  parameter int unsigned T_EN    = 24,
  parameter int unsigned T_HOLD  = 4,
  parameter int unsigned T_EXEC  = 2000,
  parameter int unsigned T_CLR   = 80000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_rs,
  input  logic [7:0]  i_data,
  output logic        o_ready,
  output logic        o_init_done,
  output logic [31:0] o_io_lcd
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned T_MAX = max2(max2(max2(T_PWR, T_SETUP), max2(T_EN, T_HOLD)),
                                       max2(T_EXEC, T_CLR));
  localparam int unsigned CW    = $clog2(T_MAX + 1);

  // Each state lasts (load + 1) cycles; PWR is preloaded with T_PWR so the
  // first init SETUP is entered at edge T_PWR+1 after reset release.
  localparam logic [CW-1:0] C_PWR   = CW'(T_PWR);
  localparam logic [CW-1:0] C_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] C_EN    = CW'(T_EN - 1);
  localparam logic [CW-1:0] C_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] C_EXEC  = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] C_CLR   = CW'(T_CLR - 1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_PWR   = 3'd0,
    S_SETUP = 3'd1,
    S_EN    = 3'd2,
    S_HOLD  = 3'd3,
    S_EXEC  = 3'd4,
    S_IDLE  = 3'd5
  } state_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    idx_q, idx_d;
  logic          init_done_q, init_done_d;
  logic          on_q;
  logic          cnt_zero;
  logic          long_exec;

  assign cnt_zero  = (cnt_q == '0);
  // Clear display and return home need the long execution wait.
  assign long_exec = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_PWR;
      cnt_q       <= C_PWR;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      idx_q       <= 2'd0;
      init_done_q <= 1'b0;
      on_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      on_q        <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_zero ? cnt_q : (cnt_q - C_ONE);
    rs_d        = rs_q;
    data_d      = data_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    case (state_q)
      S_PWR: begin
        if (cnt_zero) begin
          state_d = S_SETUP;
          cnt_d   = C_SETUP;
          rs_d    = 1'b0;
          data_d  = init_cmd(2'd0);
          idx_d   = 2'd0;
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_d = S_EN;
          cnt_d   = C_EN;
        end
      end
      S_EN: begin
        if (cnt_zero) begin
          state_d = S_HOLD;
          cnt_d   = C_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_zero) begin
          state_d = S_EXEC;
          cnt_d   = long_exec ? C_CLR : C_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_zero) begin
          if (init_done_q || (idx_q == 2'd3)) begin
            state_d     = S_IDLE;
            init_done_d = 1'b1;
          end else begin
            // Init commands chain directly into the next SETUP with no idle gap.
            state_d = S_SETUP;
            cnt_d   = C_SETUP;
            rs_d    = 1'b0;
            data_d  = init_cmd(idx_q + 2'd1);
            idx_d   = idx_q + 2'd1;
          end
        end
      end
      S_IDLE: begin
        if (i_req) begin
          state_d = S_SETUP;
          cnt_d   = C_SETUP;
          rs_d    = i_rs;
          data_d  = i_data;
        end
      end
      default: begin
        state_d = S_PWR;
        cnt_d   = C_PWR;
      end
    endcase
  end

  assign o_ready     = (state_q == S_IDLE);
  assign o_init_done = init_done_q;
  assign o_io_lcd    = {on_q, 20'd0, (state_q == S_EN), rs_q, 1'b0, data_q};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: randomized writes scored against a schedule-level model of
// EN pulses, payload changes, o_ready returns and init completion.
module tb_lcd_ctrl;

  localparam int T_PWR   = 10;
  localparam int T_SETUP = 2;
  localparam int T_EN    = 4;
  localparam int T_HOLD  = 2;
  localparam int T_EXEC  = 5;
  localparam int T_CLR   = 20;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_req;
  logic        i_rs;
  logic [7:0]  i_data;
  logic        o_ready;
  logic        o_init_done;
  logic [31:0] o_io_lcd;

  lcd_ctrl #(
    .T_PWR(T_PWR), .T_SETUP(T_SETUP), .T_EN(T_EN),
    .T_HOLD(T_HOLD), .T_EXEC(T_EXEC), .T_CLR(T_CLR)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_req(i_req),
    .i_rs(i_rs),
    .i_data(i_data),
    .o_ready(o_ready),
    .o_init_done(o_init_done),
    .o_io_lcd(o_io_lcd)
  );

  // clock / reset / edge numbering (edge 1 = first rising edge with reset released)
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int edge_n;
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) edge_n <= 0;
    else          edge_n <= edge_n + 1;
  end

  // scoreboard state
  logic [8:0] exp_q[$];   // {rs, data} of each expected write, in order
  int         exp_t_q[$]; // edge after which EN is expected to rise
  int         rdy_q[$];   // edges after which o_ready is expected to rise
  int         exp_done;
  int         n_checks;
  int         n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t edge=%0d)", name, act, exp, $time, edge_n);
    end
  endtask

  function automatic int exec_time(input logic rs, input logic [7:0] d);
    if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return T_CLR;
    return T_EXEC;
  endfunction

  function automatic int write_len(input logic rs, input logic [7:0] d);
    return T_SETUP + T_EN + T_HOLD + exec_time(rs, d);
  endfunction

  task automatic push_init();
    logic [7:0] cmds[4];
    int s;
    cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h01; cmds[3] = 8'h06;
    s = 1 + T_PWR;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, cmds[i]});
      exp_t_q.push_back(s + T_SETUP);
      s += write_len(1'b0, cmds[i]);
    end
    rdy_q.push_back(s);
    exp_done = s;
  endtask

  // driver: called just after a falling edge; returns transfer edge k (-1 on timeout)
  task automatic send(input logic rs, input logic [7:0] d, output int k);
    int n;
    n = 0;
    i_req = 1'b1; i_rs = rs; i_data = d;
    while (!o_ready && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    check("send_ready_seen", o_ready, 1'b1);
    if (!o_ready) begin
      i_req = 1'b0;
      k = -1;
      return;
    end
    k = edge_n + 1;
    exp_q.push_back({rs, d});
    exp_t_q.push_back(k + T_SETUP);
    rdy_q.push_back(k + write_len(rs, d));
    @(negedge i_clk);
    check("ready_drop_after_transfer", o_ready, 1'b0);
  endtask

  // monitor: samples on the falling edge, pops expectations as the DUT shows events
  initial begin : monitor
    logic [8:0] cur;
    logic       en, prev_en, prev_rdy, prev_done;
    logic [8:0] prev_pl;
    int         en_w;
    prev_en = 0; prev_rdy = 0; prev_done = 0; prev_pl = '0; en_w = 0;
    forever begin
      @(negedge i_clk);
      cur = {o_io_lcd[9], o_io_lcd[7:0]};
      en  = o_io_lcd[10];
      if (!i_rst_n) begin
        prev_en = 0; prev_rdy = 0; prev_done = 0; prev_pl = '0; en_w = 0;
      end else begin
        if (edge_n >= 1)
          check("static_bits", {o_io_lcd[31:11], o_io_lcd[8]}, {1'b1, 20'd0, 1'b0});
        if (cur != prev_pl) begin
          check("payload_change_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            check("payload_value", cur, exp_q[0]);
            check("payload_change_edge", edge_n, exp_t_q[0] - T_SETUP);
          end
          prev_pl = cur;
        end
        if (en && !prev_en) begin
          check("en_rise_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            check("en_payload", cur, exp_q.pop_front());
            check("en_rise_edge", edge_n, exp_t_q.pop_front());
          end
          en_w = 1;
        end else if (en) begin
          en_w++;
        end else if (prev_en) begin
          check("en_width", en_w, T_EN);
        end
        prev_en = en;
        if (o_ready && !prev_rdy) begin
          check("ready_rise_expected", rdy_q.size() != 0, 1'b1);
          if (rdy_q.size() != 0) check("ready_rise_edge", edge_n, rdy_q.pop_front());
        end
        prev_rdy = o_ready;
        if (o_init_done && !prev_done) begin
          check("init_done_edge", edge_n, exp_done);
          check("init_done_with_ready", o_ready, 1'b1);
        end
        if (!o_init_done && prev_done) check("init_done_sticky", o_init_done, 1'b1);
        prev_done = o_init_done;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin : stim
    logic       rs;
    logic [7:0] d;
    int         k, k1, k2, n;
    n_checks = 0; n_fail = 0; exp_done = 0;
    i_rst_n = 1'b0; i_req = 1'b0; i_rs = 1'b0; i_data = 8'h00;
    repeat (3) @(negedge i_clk);
    check("reset_io_lcd", o_io_lcd, 32'd0);
    check("reset_ready", o_ready, 1'b0);
    check("reset_init_done", o_init_done, 1'b0);
    #1 i_rst_n = 1'b1;
    push_init();

    // request with a changing payload during init must be ignored
    while (edge_n < 19) @(negedge i_clk);
    i_req = 1'b1;
    while (edge_n < 70) begin
      i_rs = 1'($urandom_range(0, 1));
      i_data = 8'($urandom_range(0, 255));
      @(negedge i_clk);
    end
    send(1'b1, 8'h5A, k);
    check("first_transfer_edge", k, exp_done + 1);
    i_req = 1'b0;

    send(1'b1, 8'h41, k);
    i_req = 1'b0;
    send(1'b0, 8'h01, k);
    i_req = 1'b0;

    // back-to-back with i_req held
    send(1'b1, 8'h48, k1);
    send(1'b1, 8'h49, k2);
    i_req = 1'b0;
    check("b2b_spacing", k2 - k1, write_len(1'b1, 8'h48) + 1);

    for (int i = 0; i < 14; i++) begin
      rs = 1'($urandom_range(0, 1));
      d  = 8'($urandom_range(0, 255));
      if (!rs && $urandom_range(0, 2) == 0) d = 8'($urandom_range(1, 3));
      send(rs, d, k);
      if ($urandom_range(0, 2) != 0) begin
        i_req = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge i_clk);
      end
    end
    i_req = 1'b0;

    // reset while EN is high during a data write
    send(1'b1, 8'h77, k);
    i_req = 1'b0;
    n = 0;
    while (!o_io_lcd[10] && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    check("en_high_before_reset", o_io_lcd[10], 1'b1);
    #2 i_rst_n = 1'b0;
    #1;
    check("midreset_io_lcd", o_io_lcd, 32'd0);
    check("midreset_ready", o_ready, 1'b0);
    check("midreset_init_done", o_init_done, 1'b0);
    exp_q.delete(); exp_t_q.delete(); rdy_q.delete();
    repeat (2) @(negedge i_clk);
    #1 i_rst_n = 1'b1;
    push_init();
    send(1'b1, 8'h33, k);
    check("rerun_first_transfer_edge", k, exp_done + 1);
    i_req = 1'b0;

    n = 0;
    while ((exp_q.size() != 0 || rdy_q.size() != 0) && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    check("drain_writes", exp_q.size(), 0);
    check("drain_ready", rdy_q.size(), 0);
    repeat (3) @(negedge i_clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Write sequencer for the character-LCD port of the single-cycle CPU's I/O subsystem. It accepts one byte per request from the LSU side, either a command (RS=0) or data (RS=1), over a ready/valid handshake. It drives the HD44780-style `o_io_lcd` word with correct setup/enable/hold spacing and waits out the controller's execution time. After reset it autonomously runs the panel power-up/init sequence before accepting requests.

## Interface
Parameters (all in i_clk cycles, each ≥1):
- T_PWR, 2000000: power-on wait before the first init command.
- T_SETUP, 4: RS/DATA valid before EN rises.
- T_EN, 24: EN high width.
- T_HOLD, 4: RS/DATA held after EN falls.
- T_EXEC, 2000: post-write wait, normal commands and data.
- T_CLR, 80000: post-write wait for clear/home commands.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req  in  1  write request (valid).
- i_rs  in  1  0 = command, 1 = data; sampled with i_req.
- i_data  in  8  byte to write; sampled with i_req.
- o_ready  out  1  block can accept a request this cycle.
- o_init_done  out  1  init sequence completed; stays 1 until reset.
- o_io_lcd  out  32  bit [31] ON, bits [30:11] 0, bit [10] EN, bit [9] RS, bit [8] RW (always 0), bits [7:0] DATA.

## Operation
- FSM states: PWR, SETUP, EN, HOLD, EXEC, IDLE.
- A single down-counter, width $clog2(max param + 1), times every state.
- Reset drives state PWR with counter = T_PWR. Reset values: o_io_lcd = 0 (ON = 0), o_ready = 0, o_init_done = 0.
- ON = 1 from the first rising edge with i_rst_n high, and stays 1.
- The init sequence issues commands 0x38, 0x0C, 0x01, 0x06, each as a full SETUP→EN→HOLD→EXEC write with RS = 0. There is no idle gap between init commands.
- Transfer condition: i_req && o_ready at a rising edge. The block latches i_rs and i_data and goes IDLE→SETUP.
- o_ready = 1 only in IDLE. Requests outside IDLE are ignored; the requester must hold i_req, i_rs and i_data.
- EXEC duration is T_CLR if RS = 0 and DATA ∈ {0x01, 0x02, 0x03}; otherwise T_EXEC.
- RS and DATA stay constant from SETUP entry until the next transfer, including through IDLE. EN = 1 only in the EN state.
- After the last init EXEC completes, o_init_done rises together with o_ready.

## Timing
- All outputs are registered or decoded from registered state. They change only at i_clk rising edges, except on asynchronous reset.
- Per write, with the transfer at edge k:
  - SETUP holds for edges k .. k+T_SETUP−1.
  - EN = 1 after edge k+T_SETUP, for T_EN cycles.
  - HOLD lasts T_HOLD cycles.
  - EXEC lasts Tw cycles (Tw = T_EXEC or T_CLR).
  - o_ready is 1 again after edge k+T_SETUP+T_EN+T_HOLD+Tw.
- If i_req is held continuously, back-to-back transfers are spaced T_SETUP+T_EN+T_HOLD+Tw+1 edges apart.
- Init timing: PWR occupies edges 1..T_PWR, where edge 1 is the first edge with i_rst_n high. o_init_done and o_ready first go high after edge 1+T_PWR+4·(T_SETUP+T_EN+T_HOLD)+3·T_EXEC+T_CLR.
- Reset mid-write or mid-init: outputs go to reset values immediately, with EN forced to 0. The full init sequence reruns; there is no partial resume.
- i_req asserted with a changing payload while o_ready = 0: no effect. Only the value at the transfer edge is used.

## Test plan
All scenarios use T_PWR=10, T_SETUP=2, T_EN=4, T_HOLD=2, T_EXEC=5, T_CLR=20.
- Reset then release, no requests → o_io_lcd = 0 during reset. After edge 1, ON = 1. EN pulses 4 times, each pulse 4 cycles wide, with DATA 0x38, 0x0C, 0x01, 0x06 and RS = 0. o_ready and o_init_done go high after edge 78.
- After init, i_req=1, i_rs=1, i_data=0x41 for one cycle at edge k → o_ready low after edge k. o_io_lcd[9:0] = 0x241 with EN = 0 for 2 cycles, then EN = 1 for 4 cycles, then EN = 0. o_ready is high after edge k+13.
- Command 0x01 (RS = 0) → same EN timing as above, but o_ready returns after edge k+28.
- i_req held high with two queued bytes 0x48 then 0x49 → the transfers are exactly 14 edges apart. No EN overlap occurs, and DATA changes only at the second transfer edge.
- i_req asserted during init (at edge 20) → ignored. o_io_lcd follows the init sequence unchanged, and the request is accepted at the first edge after edge 78.
- i_rst_n pulsed low while EN = 1 during a data write → EN and ON drop immediately, o_ready = 0, and the init sequence restarts from PWR with identical timing.
